// File: rtl/ps2_key_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | ps2_key_ctrl_if                                                            |
// | FIFO-side and event-side signal bundle for ps2_key_ctrl.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ps2_key_ctrl_if;
  logic [7:0]   kb_data;
  logic         kb_ready;
  logic         kb_overflow;
  logic         kb_rdn;
  logic         ev_valid;
  logic [7:0]   ev_code;
  logic         ev_ext;
  logic         ev_break;
  logic         ev_ack;
  logic [255:0] key_down;
  logic [7:0]   ovf_cnt;

  modport master (
    input  kb_data, kb_ready, kb_overflow, ev_ack,
    output kb_rdn, ev_valid, ev_code, ev_ext, ev_break, key_down, ovf_cnt
  );

  modport slave (
    output kb_data, kb_ready, kb_overflow, ev_ack,
    input  kb_rdn, ev_valid, ev_code, ev_ext, ev_break, key_down, ovf_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
// +----------------------------------------------------------------------------+
// | ps2_key_ctrl                                                               |
// | Folds PS/2 Set-2 prefixes from the receive FIFO into key events.           |
// | Optional held-key bitmap enabled by defining PS2_KEYMAP_EN.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_key_ctrl #(
  parameter int PAUSE_SKIP = 7
) (
  input  logic           clk,
  input  logic           clr,
  ps2_key_ctrl_if.master bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EMIT   = 3'd3;
  localparam logic [2:0] c_SKIP   = 3'd4;

  localparam int                c_SKIP_W    = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);
  localparam logic [c_SKIP_W-1:0] c_SKIP_LOAD = c_SKIP_W'(PAUSE_SKIP);

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic                r_kb_rdn;
  logic [7:0]          r_byte;
  logic                r_ext_f;
  logic                r_brk_f;
  logic [c_SKIP_W-1:0] r_skip_cnt;
  logic [7:0]          r_ev_code;
  logic                r_ev_ext;
  logic                r_ev_break;
  logic                r_ovf_hist;
  logic [7:0]          r_ovf_cnt;

  logic w_ovf_rise;
  logic w_ext_eff;
  logic w_brk_eff;
  logic w_is_prefix;
  logic w_is_err;
  logic w_is_pause;
  logic w_ev_valid;
  logic w_pop_next;

  // An overflow edge in the DECODE cycle must already mask the flags.
  assign w_ovf_rise  = bus.kb_overflow & ~r_ovf_hist;
  assign w_ext_eff   = r_ext_f & ~w_ovf_rise;
  assign w_brk_eff   = r_brk_f & ~w_ovf_rise;
  assign w_is_prefix = (r_byte == 8'hE0) || (r_byte == 8'hF0);
  assign w_is_err    = (r_byte == 8'h00) || (r_byte == 8'hFF);
  assign w_is_pause  = (r_byte == 8'hE1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (bus.kb_ready) w_next = c_FETCH;
      c_FETCH:  w_next = c_DECODE;
      c_DECODE: w_next = (w_is_prefix || w_is_err) ? c_IDLE : c_EMIT;
      c_EMIT:   if (bus.ev_ack) w_next = (r_skip_cnt != '0) ? c_SKIP : c_IDLE;
      c_SKIP:   if (r_skip_cnt == '0) w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // SKIP alternates a decision cycle with a pop cycle, mirroring FETCH.
  always_comb begin
    w_ev_valid = (r_state == c_EMIT);
    w_pop_next = ((r_state == c_IDLE) && bus.kb_ready) ||
                 ((r_state == c_SKIP) && (r_skip_cnt != '0) && r_kb_rdn && bus.kb_ready);
  end

  assign bus.kb_rdn   = r_kb_rdn;
  assign bus.ev_valid = w_ev_valid;
  assign bus.ev_code  = r_ev_code;
  assign bus.ev_ext   = r_ev_ext;
  assign bus.ev_break = r_ev_break;
  assign bus.ovf_cnt  = r_ovf_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_kb_rdn   <= 1'b1;
      r_byte     <= 8'h00;
      r_ext_f    <= 1'b0;
      r_brk_f    <= 1'b0;
      r_skip_cnt <= '0;
      r_ev_code  <= 8'h00;
      r_ev_ext   <= 1'b0;
      r_ev_break <= 1'b0;
      r_ovf_hist <= 1'b0;
      r_ovf_cnt  <= 8'h00;
    end else begin
      r_kb_rdn   <= ~w_pop_next;
      r_ovf_hist <= bus.kb_overflow;

      if (w_ovf_rise && (r_ovf_cnt != 8'hFF))
        r_ovf_cnt <= r_ovf_cnt + 8'd1;

      if (r_state == c_FETCH)
        r_byte <= bus.kb_data;

      if (w_ovf_rise) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end else if (r_state == c_DECODE) begin
        r_ext_f <= (r_byte == 8'hE0) ? 1'b1 : ((r_byte == 8'hF0) ? r_ext_f : 1'b0);
        r_brk_f <= (r_byte == 8'hF0) ? 1'b1 : ((r_byte == 8'hE0) ? r_brk_f : 1'b0);
      end

      if ((r_state == c_DECODE) && !w_is_prefix && !w_is_err) begin
        r_ev_code  <= r_byte;
        r_ev_ext   <= w_is_pause ? 1'b0 : w_ext_eff;
        r_ev_break <= w_is_pause ? 1'b0 : w_brk_eff;
      end

      if ((r_state == c_DECODE) && w_is_pause)
        r_skip_cnt <= c_SKIP_LOAD;
      else if ((r_state == c_SKIP) && !r_kb_rdn && (r_skip_cnt != '0))
        r_skip_cnt <= r_skip_cnt - 1'b1;
    end
  end

`ifdef PS2_KEYMAP_EN
  logic [255:0] r_key_down;

  // Extended codes live in the upper half; bit-7 codes never touch the map.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_key_down <= '0;
    else if ((r_state == c_DECODE) && !w_is_prefix && !w_is_err && !r_byte[7])
      r_key_down[{w_ext_eff, r_byte[6:0]}] <= ~w_brk_eff;
  end

  assign bus.key_down = r_key_down;
`else
  assign bus.key_down = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_ps2_key_ctrl                                                            |
// | Directed self-checking bench for ps2_key_ctrl with a behavioural FIFO.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_ctrl;

`ifdef PS2_KEYMAP_EN
  localparam bit c_KM = 1'b1;
`else
  localparam bit c_KM = 1'b0;
`endif

  logic clk;
  logic clr;
  ps2_key_ctrl_if bus();

  ps2_key_ctrl #(.PAUSE_SKIP(7)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   q[$];
  int           pop_cnt  = 0;
  int           ev_cnt   = 0;
  int           rdn_viol = 0;
  bit           prev_low = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [255:0] exp_kd   = '0;

  // Pops land just after the edge that ends a low-rdn cycle; the head is
  // refreshed again after the negedge so bench pushes are visible in time.
  always begin
    bit was_low;
    logic [7:0] tmp;
    @(posedge clk);
    was_low = !bus.kb_rdn;
    #1;
    if (was_low && q.size() != 0) begin
      tmp = q.pop_front();
      pop_cnt++;
    end
    bus.kb_ready = (q.size() != 0);
    bus.kb_data  = (q.size() != 0) ? q[0] : 8'h00;
    #5;
    bus.kb_ready = (q.size() != 0);
    bus.kb_data  = (q.size() != 0) ? q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (bus.ev_valid && bus.ev_ack) ev_cnt++;
    if (!bus.kb_rdn && prev_low) rdn_viol++;
    prev_low = !bus.kb_rdn;
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.ev_valid && n < 40) begin
      step();
      n++;
    end
    check_eq(tag, bus.ev_valid, 1'b1);
  endtask

  function automatic logic [255:0] kd_exp();
    return c_KM ? exp_kd : '0;
  endfunction

  initial begin
    int ev_base;
    clr             = 1'b1;
    bus.ev_ack      = 1'b0;
    bus.kb_overflow = 1'b0;
    bus.kb_data     = 8'h00;
    bus.kb_ready    = 1'b0;
    step(); step();
    check_eq("rst_rdn",   bus.kb_rdn, 1'b1);
    check_eq("rst_event", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, 11'h000);
    check_eq("rst_kd",    bus.key_down, '0);
    check_eq("rst_ovf",   bus.ovf_cnt, 8'h00);
    clr = 1'b0;
    step();

    // Single make code, exact cycle latency
    bus.ev_ack = 1'b1;
    q.push_back(8'h1C);
    step(); check_eq("t1_rdn_fetch", bus.kb_rdn, 1'b0);
    step(); check_eq("t1_decode", {bus.kb_rdn, bus.ev_valid}, 2'b10);
    step();
    exp_kd[8'h1C] = 1'b1;
    check_eq("t1_event", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, {1'b1, 8'h1C, 2'b00});
    check_eq("t1_kd", bus.key_down, kd_exp());
    step(); check_eq("t1_acked", bus.ev_valid, 1'b0);
    check_eq("t1_pops", pop_cnt, 1);

    // Break of the same key
    pop_cnt = 0;
    q.push_back(8'hF0); q.push_back(8'h1C);
    wait_valid("t2_valid");
    exp_kd[8'h1C] = 1'b0;
    check_eq("t2_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h1C, 2'b01});
    check_eq("t2_pops", pop_cnt, 2);
    step();
    check_eq("t2_kd", bus.key_down, kd_exp());

    // Extended break held without ack; backlog must wait
    bus.ev_ack = 1'b0;
    pop_cnt = 0;
    q.push_back(8'hE0); q.push_back(8'hF0); q.push_back(8'h75); q.push_back(8'h16);
    wait_valid("t3_valid");
    for (int i = 0; i < 10; i++) begin
      check_eq("t3_hold", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break, bus.kb_ready},
               {1'b1, 8'h75, 2'b11, 1'b1});
      check_eq("t3_nopop", pop_cnt, 3);
      step();
    end
    bus.ev_ack = 1'b1;
    step();
    check_eq("t3_release", bus.ev_valid, 1'b0);
    wait_valid("t3_next_valid");
    exp_kd[8'h16] = 1'b1;
    check_eq("t3_next", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h16, 2'b00});
    step();
    check_eq("t3_kd", bus.key_down, kd_exp());

    // Pause sequence: one event, remaining bytes discarded
    pop_cnt = 0;
    ev_base = ev_cnt;
    q.push_back(8'hE1); q.push_back(8'h14); q.push_back(8'h77); q.push_back(8'hE1);
    q.push_back(8'hF0); q.push_back(8'h14); q.push_back(8'hF0); q.push_back(8'h77);
    wait_valid("t4_valid");
    check_eq("t4_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'hE1, 2'b00});
    for (int i = 0; i < 60 && pop_cnt < 8; i++) step();
    for (int i = 0; i < 6; i++) step();
    check_eq("t4_pops", pop_cnt, 8);
    check_eq("t4_events", ev_cnt - ev_base, 1);
    check_eq("t4_idle", {bus.ev_valid, bus.kb_ready}, 2'b00);
    check_eq("t4_kd", bus.key_down, kd_exp());

    // Overflow after a consumed E0 prefix drops the prefix
    q.push_back(8'hE0);
    for (int i = 0; i < 6; i++) step();
    bus.kb_overflow = 1'b1; step();
    bus.kb_overflow = 1'b0; step();
    q.push_back(8'h29);
    wait_valid("t5_valid");
    exp_kd[8'h29] = 1'b1;
    check_eq("t5_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h29, 2'b00});
    check_eq("t5_ovf", bus.ovf_cnt, 8'h01);
    step();
    check_eq("t5_kd", bus.key_down, kd_exp());

    // Overflow edge coinciding with DECODE
    q.push_back(8'hE0);
    for (int i = 0; i < 6; i++) step();
    q.push_back(8'h74);
    step(); step();
    bus.kb_overflow = 1'b1;
    wait_valid("t5b_valid");
    bus.kb_overflow = 1'b0;
    exp_kd[8'h74] = 1'b1;
    check_eq("t5b_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h74, 2'b00});
    check_eq("t5b_ovf", bus.ovf_cnt, 8'h02);
    step();
    check_eq("t5b_kd", bus.key_down, kd_exp());

    // Error byte dropped; bit-7 code emits but leaves the bitmap alone
    pop_cnt = 0;
    ev_base = ev_cnt;
    q.push_back(8'h00); q.push_back(8'h83);
    wait_valid("t6_valid");
    check_eq("t6_event", {bus.ev_code, bus.ev_ext, bus.ev_break}, {8'h83, 2'b00});
    step(); step();
    check_eq("t6_events", ev_cnt - ev_base, 1);
    check_eq("t6_pops", pop_cnt, 2);
    check_eq("t6_kd", bus.key_down, kd_exp());

    // Overflow counter saturation
    for (int i = 0; i < 260; i++) begin
      bus.kb_overflow = 1'b1; step();
      bus.kb_overflow = 1'b0; step();
    end
    check_eq("t7_ovf_sat", bus.ovf_cnt, 8'hFF);

    // Asynchronous clear in the middle of FETCH
    q.push_back(8'h1C);
    step();
    check_eq("t8_in_fetch", bus.kb_rdn, 1'b0);
    clr = 1'b1;
    #1;
    check_eq("t8_rdn", bus.kb_rdn, 1'b1);
    check_eq("t8_event", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_break}, 11'h000);
    check_eq("t8_kd", bus.key_down, '0);
    check_eq("t8_ovf", bus.ovf_cnt, 8'h00);
    step();
    clr = 1'b0;
    step();

    check_eq("rdn_single_cycle", rdn_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller between the `ps2_keyboard` receive FIFO and the game logic. It drains bytes from the FIFO with a one-cycle `rdn` pop and folds Set-2 prefixes (`E0`, `F0`, `E1`) into single key events. Events are presented on a valid/ack handshake, and the block optionally maintains a held-key bitmap for direct polling by the fruit/blade logic.

## Interface

Parameters:
- `PAUSE_SKIP`, default 7: bytes discarded after an `E1` prefix.

Ports:
- `clk` in 1: system clock; the same clock as `ps2_keyboard`.
- `clr` in 1: reset, asynchronous and active-high.
- `kb_data` in 8: `ps2_keyboard.data`, the FIFO head (combinational).
- `kb_ready` in 1: `ps2_keyboard.ready`, FIFO non-empty.
- `kb_overflow` in 1: `ps2_keyboard.overflow`.
- `kb_rdn` out 1: to `ps2_keyboard.rdn`; active-low pop.
- `ev_valid` out 1: a key event is pending.
- `ev_code` out 8: scan code of the event.
- `ev_ext` out 1: event was `E0`-prefixed.
- `ev_break` out 1: 1 = release, 0 = press.
- `ev_ack` in 1: consumer accepts the event.
- `key_down` out 256: held-key bitmap indexed `{ext, code[6:0]}`.
- `ovf_cnt` out 8: saturating count of FIFO overflow episodes.

## Operation

FSM states: IDLE, FETCH, DECODE, EMIT, SKIP.

- **IDLE:** if `kb_ready` and `ev_valid`=0, go to FETCH; otherwise stay.
- **FETCH:** `kb_rdn`=0 for exactly this one cycle. `kb_data` is latched into `byte_r` at the exiting edge; the FIFO pops on the same edge. Next state is DECODE.
- **DECODE:** one cycle; `kb_rdn`=1. Action depends on `byte_r`:
  - `E0`: set `ext_f`, go to IDLE.
  - `F0`: set `brk_f`, go to IDLE.
  - `E1`: load the skip counter with `PAUSE_SKIP`, clear the flags, then load the event (code `E1`, ext 0, break 0) and go to EMIT.
  - `00` or `FF` (keyboard error): clear the flags, no event, go to IDLE.
  - Any other byte: load `ev_code`=`byte_r`, `ev_ext`=`ext_f`, `ev_break`=`brk_f`; clear both flags; update the bitmap; go to EMIT.
- **EMIT:** `ev_valid`=1 with all event fields stable until `ev_ack`=1. On ack, go to SKIP if the skip counter is nonzero, else IDLE.
- **SKIP:** pops and discards bytes using the same FETCH timing (rdn low one cycle per byte, only while `kb_ready`), decrementing the counter. When the counter reaches 0, go to IDLE.

Overflow handling:
- A rising edge of `kb_overflow`, registered in a 1-bit history flop, increments `ovf_cnt`, saturating at `FF`.
- The same edge clears `ext_f` and `brk_f` so that a truncated prefix cannot corrupt the next event.

Other rules:
- `ev_ack` while `ev_valid`=0 is ignored.
- No bytes are popped while an event is pending; the FIFO absorbs the backlog.

## Timing

- Reset values: `kb_rdn`=1, `ev_valid`=0, `ev_code`=00, `ev_ext`=0, `ev_break`=0, `key_down`=0, `ovf_cnt`=0. Also: state IDLE, flags 0, skip counter 0.
- Asserting `clr` mid-transaction aborts immediately. A byte popped in FETCH is lost; this is acceptable.
- Latency for a single-byte make code: `kb_ready` high at cycle 0 → FETCH at 1 → DECODE at 2 → `ev_valid` at 3.
- Each prefix byte costs 3 cycles (IDLE, FETCH, DECODE).
- `ev_ack` sampled high in EMIT → `ev_valid`=0 the next cycle → FETCH possible one cycle after that.
- Back-to-back throughput is at most one event per 4 cycles with ack tied high.
- `kb_rdn` is a registered output. It is never low for more than one consecutive cycle, and never low when `kb_ready` was 0 at the FETCH decision.
- Overflow rising edge and DECODE in the same cycle: the flag clear wins, and the decoded byte is emitted with ext=0 and break=0.

## Configuration

- `PS2_KEYMAP_EN` defined:
  - `key_down[{ext, code[6:0]}]` is set on make and cleared on break, in the DECODE cycle, independent of `ev_ack`.
  - Codes with bit 7 set (including `E1` and `83`) do not touch the bitmap.
- Not defined: `key_down` is tied to 0 and no bitmap storage is built.

## Test plan

- FIFO bytes `1C`, ack tied 1 → `kb_rdn` low exactly 1 cycle; `ev_valid` 3 cycles after `kb_ready` with code 1C, ext 0, break 0; `key_down[0x1C]`=1.
- Bytes `F0 1C` → one event: code 1C, break 1; `key_down[0x1C]`=0; 2 pops total.
- Bytes `E0 F0 75` with ack held 0 for 10 cycles → `ev_valid` and code 75 / ext 1 / break 1 stable all 10 cycles; `kb_ready` stays 1 and no further pops occur until ack.
- Pause sequence `E1 14 77 E1 F0 14 F0 77` → exactly one event (code E1), 8 pops, `key_down` unchanged.
- Force `kb_overflow` 0→1 after `E0` was consumed, then byte `29` → event code 29 with ext 0; `ovf_cnt`=1. Asserting `clr` during FETCH → all outputs return to reset values within the same cycle.
